// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, rw convention and widths for the core-bus RAM bridge
package bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam int BUS_W = 16;
  localparam logic [BUS_W-1:0] PROT_TOP_DEF = 16'h003F;
endpackage

// File: rtl/bus_ram_array.sv
// bus_ram_array: single-port synchronous RAM with registered read, optionally zero-initialised
module bus_ram_array
  import bus_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter bit INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BUS_W-1:0]  wdata,
  output logic [BUS_W-1:0]  rdata
);
  if (INIT_ZERO) begin : g_zero
    logic [BUS_W-1:0] mem [2**ADDR_W] = '{default: '0};
    // write port and read-first registered read
    always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end else begin : g_raw
    logic [BUS_W-1:0] mem [2**ADDR_W];
    // write port and read-first registered read
    always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/bus_ram_bridge.sv
// bus_ram_bridge: wait-state RAM slave for the core bus; BUS_RAM_WR_PROTECT_EN adds low-region write protection
module bus_ram_bridge
  import bus_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAIT_STATES = 2,
  parameter bit INIT_ZERO = 1
`ifdef BUS_RAM_WR_PROTECT_EN
  , parameter logic [BUS_W-1:0] PROT_TOP = PROT_TOP_DEF
`endif
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_req,
  input  logic             i_rw,
  input  logic [BUS_W-1:0] i_addr,
  input  logic [BUS_W-1:0] i_wdata,
  output logic [BUS_W-1:0] o_rdata,
  output logic             o_rdata_oe,
  output logic             o_lock,
  output logic             o_ack,
  output logic             o_err
);
  state_t state;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr_q, ram_addr;
  logic rw_q, bad_q, cur_rw, cur_bad, accept, go_resp, in_range, prot, we;
  logic [BUS_W-1:0] wdata_q, ram_wdata, ram_rdata, rdata_hold;
  assign in_range = (32'(i_addr) >> ADDR_W) == 32'd0;
`ifdef BUS_RAM_WR_PROTECT_EN
  assign prot = i_rw == RW_WRITE && i_addr <= PROT_TOP;
`else
  assign prot = 1'b0;
`endif
  assign accept = state == IDLE && i_req;
  assign go_resp = (accept && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd0);
  assign ram_addr = state == IDLE ? i_addr[ADDR_W-1:0] : addr_q;
  assign ram_wdata = state == IDLE ? i_wdata : wdata_q;
  assign cur_rw = state == IDLE ? i_rw : rw_q;
  assign cur_bad = state == IDLE ? (!in_range || prot) : bad_q;
  assign we = go_resp && cur_rw == RW_WRITE && !cur_bad;
  assign o_lock = n_rst && (accept || state == WAIT);
  assign o_rdata = o_rdata_oe ? (bad_q ? '0 : ram_rdata) : rdata_hold;
  bus_ram_array #(.ADDR_W(ADDR_W), .INIT_ZERO(INIT_ZERO)) u_array (
    .clk(clk), .we(we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
  );
  // access sequencing: accept in IDLE, count wait states, one-cycle response
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      rw_q <= RW_READ;
      wdata_q <= '0;
      bad_q <= 1'b0;
      rdata_hold <= '0;
      o_ack <= 1'b0;
      o_err <= 1'b0;
      o_rdata_oe <= 1'b0;
    end else begin
      o_ack <= go_resp;
      o_err <= go_resp && cur_bad;
      o_rdata_oe <= go_resp && cur_rw == RW_READ;
      if (o_rdata_oe) rdata_hold <= o_rdata;
      case (state)
        IDLE: if (i_req) begin
          addr_q <= i_addr[ADDR_W-1:0];
          rw_q <= i_rw;
          wdata_q <= i_wdata;
          bad_q <= !in_range || prot;
          cnt <= WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
          state <= WAIT_STATES == 0 ? RESP : WAIT;
        end
        WAIT: if (cnt == 4'd0) state <= RESP;
              else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
